distribute_1x2_ctrl: RTL and testbench
======================================

# distribute_1x2_ctrl

Issue controller for the `distribute_1x2_seq` switch. It accepts destination-tagged beats on a valid/ready input and holds each beat in a single-entry register. It drives the switch's `i_valid`/`i_en`/`i_cmd`/`i_data_bus` only toward outputs whose downstream consumer is ready. It sits directly upstream of one switch instance in the distribution tree and keeps per-leg issue counters for debug.

## Interface
- `DATA_WIDTH`, 32, beat width; matches the switch.
- `COMMMAND_WIDTH`, 2, switch command width; fixed at 2.
- `CNT_WIDTH`, 16, width of each per-leg issue counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  upstream beat valid.
- `i_ready`  out  1  upstream beat accepted when `i_valid && i_ready`.
- `i_data_bus`  in  DATA_WIDTH  upstream beat data.
- `i_dest`  in  2  destination mask: bit1 = high leg, bit0 = low leg.
- `i_ready_high`  in  1  high-leg consumer can take a beat this cycle.
- `i_ready_low`  in  1  low-leg consumer can take a beat this cycle.
- `o_sw_valid`  out  1  to switch `i_valid`.
- `o_sw_en`  out  1  to switch `i_en`.
- `o_sw_cmd`  out  COMMMAND_WIDTH  to switch `i_cmd`: 01 low, 10 high, 11 duplicate.
- `o_sw_data`  out  DATA_WIDTH  to switch `i_data_bus`.
- `o_busy`  out  1  holding register occupied.
- `o_cnt_high`  out  CNT_WIDTH  legs issued to high, saturating.
- `o_cnt_low`  out  CNT_WIDTH  legs issued to low, saturating.

## Operation
- **State.** `hold_data[DATA_WIDTH]` plus `pend[1:0]`, the legs not yet issued.
  - EMPTY: `pend == 00`.
  - FULL: `pend != 00`.
  - PARTIAL: `pend` is a strict subset of the accepted mask. Only reachable when `DIST_CTRL_SPLIT_EN` is defined.
- **Issue mask `iss[1:0]`, combinational.**
  - With split: `iss = pend & {i_ready_high, i_ready_low}`.
  - Without split: `iss = pend` if every bit of `pend` has its ready asserted, else 00.
- **Switch drive.**
  - `o_sw_cmd = iss`.
  - `o_sw_en = o_sw_valid = |iss`.
  - `o_sw_data = hold_data` when `|iss`, else all zeros (dummy data).
- **Pending update.** `pend_next = pend & ~iss`.
- **Input ready.** `i_ready = (pend_next == 00)`. This gives a combinational path from `i_ready_high`/`i_ready_low` to `i_ready` and allows full throughput.
- **Accept with `i_dest != 00`.** Load `hold_data <= i_data_bus` and `pend <= i_dest`.
- **Accept with `i_dest == 00`.** The beat is consumed and dropped. `pend` stays 00, nothing is issued, counters are unchanged.
- **Counters.** `o_cnt_high` increments when `iss[1]`; `o_cnt_low` increments when `iss[0]`. Both saturate at all-ones.
- **Busy.** `o_busy = (pend != 00)`.
- **Ordering.** Beats are issued strictly in acceptance order. No beat overtakes a partially issued one.

## Timing
- **Reset values.** `pend = 00`, `hold_data = 0`, counters = 0. As a result `i_ready = 1`, `o_sw_valid = o_sw_en = 0`, `o_sw_cmd = 00`, `o_sw_data = 0`, `o_busy = 0`.
- **Reset mid-operation.** A held or partially issued beat is discarded with no further issue.
- **Latency.** Beat accepted at edge N is issued (switch inputs driven) in cycle N+1 at the earliest. It appears on the switch outputs after edge N+1, because the switch itself is registered.
- **Back-to-back.** A beat can be accepted at the same edge the previous beat's last leg issues, sustaining 1 beat/cycle when consumers stay ready.
- **Ready deasserted.** Readies low for K cycles stall the issue K cycles. `i_ready` stays 0 throughout and the held beat is stable.
- **Non-split duplicate.** If exactly one leg is ready, nothing issues; the controller waits for both legs to be ready in the same cycle.
- **Upstream contract.** `i_valid`, `i_data_bus` and `i_dest` are held stable until accepted. The controller does not check this.

## Configuration
- `DIST_CTRL_SPLIT_EN` defined: a duplicate beat is delivered leg-by-leg as each consumer becomes ready, so PARTIAL is reachable and `o_sw_cmd` may be 01 or 10 for a beat whose mask was 11.
- Not defined: all legs of a beat issue in one cycle (all-or-nothing), `o_sw_cmd` always equals the full accepted mask, and PARTIAL never occurs.

## Test plan
- **Reset.** `rst=0` at any time gives all outputs at the reset values above, including mid-hold; after release, `i_ready=1`.
- **Streaming.** Both readies=1; stream `i_dest`=01,10,11 with data `0xAAAAAAAA`, `0xBBBBBBBB`, `0xCCCCCCCC` on consecutive cycles. Expect `o_sw_cmd` 01,10,11 on the next three cycles with matching data, `i_ready` constantly 1, and final counters high=2, low=2.
- **Duplicate with one leg stalled.** Beat dest=11 with `i_ready_low=0` for 3 cycles.
  - Split build: cmd=10 immediately, then cmd=01 once low is ready.
  - Non-split build: cmd=00 for 3 cycles, then cmd=11.
  - Both builds: `i_ready=0` until the last leg issues.
- **Drop.** Beat dest=00 is accepted in one cycle with no switch activity and no counter change; the following beat with dest=01 issues normally.
- **Saturation.** With `CNT_WIDTH=4`, issue 20 low-leg beats; expect `o_cnt_low=15`.
- **Reset while held.** Beat dest=10 held with `i_ready_high=0`; assert `rst` for 1 cycle, then set `i_ready_high=1`. Expect no issue and `o_cnt_high=0`.

Source files
------------

// File: rtl/distribute_1x2_ctrl.sv
// rtl/distribute_1x2_ctrl.sv - single-entry issue controller for a 1x2 distribution switch
// Optional leg-by-leg delivery of duplicate beats: define DIST_CTRL_SPLIT_EN.
module distribute_1x2_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int COMMMAND_WIDTH = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic [DATA_WIDTH-1:0]     i_data_bus,
    input  logic [1:0]                i_dest,
    input  logic                      i_ready_high,
    input  logic                      i_ready_low,
    output logic                      o_sw_valid,
    output logic                      o_sw_en,
    output logic [COMMMAND_WIDTH-1:0] o_sw_cmd,
    output logic [DATA_WIDTH-1:0]     o_sw_data,
    output logic                      o_busy,
    output logic [CNT_WIDTH-1:0]      o_cnt_high,
    output logic [CNT_WIDTH-1:0]      o_cnt_low
);

    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [1:0]            pend_q, pend_d;
    logic [CNT_WIDTH-1:0]  cnt_high_q, cnt_high_d;
    logic [CNT_WIDTH-1:0]  cnt_low_q, cnt_low_d;
    logic [1:0]            leg_ready;
    logic [1:0]            iss;
    logic [1:0]            pend_next;
    logic                  accept;

    always_comb begin
        leg_ready = {i_ready_high, i_ready_low};
`ifdef DIST_CTRL_SPLIT_EN
        iss = pend_q & leg_ready;
`else
        // All-or-nothing: every pending leg must be ready in the same cycle.
        iss = ((pend_q & ~leg_ready) == 2'b00) ? pend_q : 2'b00;
`endif
        pend_next = pend_q & ~iss;
        i_ready   = (pend_next == 2'b00);
        accept    = i_valid && i_ready;

        // A dest==00 beat loads pend with 00, which is simply a drop.
        pend_d      = accept ? i_dest : pend_next;
        hold_data_d = (accept && (i_dest != 2'b00)) ? i_data_bus : hold_data_q;

        cnt_high_d = (iss[1] && (cnt_high_q != '1)) ? cnt_high_q + CNT_WIDTH'(1) : cnt_high_q;
        cnt_low_d  = (iss[0] && (cnt_low_q != '1))  ? cnt_low_q + CNT_WIDTH'(1)  : cnt_low_q;

        o_sw_cmd   = COMMMAND_WIDTH'(iss);
        o_sw_valid = |iss;
        o_sw_en    = |iss;
        o_sw_data  = (|iss) ? hold_data_q : '0;
        o_busy     = (pend_q != 2'b00);
        o_cnt_high = cnt_high_q;
        o_cnt_low  = cnt_low_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_data_q <= '0;
            pend_q      <= 2'b00;
            cnt_high_q  <= '0;
            cnt_low_q   <= '0;
        end else begin
            hold_data_q <= hold_data_d;
            pend_q      <= pend_d;
            cnt_high_q  <= cnt_high_d;
            cnt_low_q   <= cnt_low_d;
        end
    end

endmodule

// File: tb/tb_distribute_1x2_ctrl.sv
// tb/tb_distribute_1x2_ctrl.sv - directed self-checking bench for distribute_1x2_ctrl
// Expectations follow DIST_CTRL_SPLIT_EN when the build defines it.
module tb_distribute_1x2_ctrl;

    localparam int DW = 32;
    localparam int CW = 4;
`ifdef DIST_CTRL_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data_bus;
    logic [1:0]    i_dest;
    logic          i_ready_high;
    logic          i_ready_low;
    logic          o_sw_valid;
    logic          o_sw_en;
    logic [1:0]    o_sw_cmd;
    logic [DW-1:0] o_sw_data;
    logic          o_busy;
    logic [CW-1:0] o_cnt_high;
    logic [CW-1:0] o_cnt_low;

    int errors = 0;
    int checks = 0;

    distribute_1x2_ctrl #(.DATA_WIDTH(DW), .COMMMAND_WIDTH(2), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_data_bus(i_data_bus), .i_dest(i_dest),
        .i_ready_high(i_ready_high), .i_ready_low(i_ready_low),
        .o_sw_valid(o_sw_valid), .o_sw_en(o_sw_en), .o_sw_cmd(o_sw_cmd), .o_sw_data(o_sw_data),
        .o_busy(o_busy), .o_cnt_high(o_cnt_high), .o_cnt_low(o_cnt_low)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs may then be changed safely.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_valid = 1'b0; i_dest = 2'b00; i_data_bus = '0;
        step(); step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; i_valid = 1'b0; i_dest = 2'b00; i_data_bus = '0;
        i_ready_high = 1'b0; i_ready_low = 1'b0;
        step(); step();
        settle();
        chk("rst_i_ready", 32'(i_ready), 32'd1);
        chk("rst_sw_valid", 32'(o_sw_valid), 32'd0);
        chk("rst_sw_en", 32'(o_sw_en), 32'd0);
        chk("rst_sw_cmd", 32'(o_sw_cmd), 32'd0);
        chk("rst_sw_data", o_sw_data, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_cnt_high", 32'(o_cnt_high), 32'd0);
        chk("rst_cnt_low", 32'(o_cnt_low), 32'd0);
        rst = 1'b1;
        step();

        // Streaming 01,10,11 with both legs ready
        i_ready_high = 1'b1; i_ready_low = 1'b1;
        i_valid = 1'b1; i_dest = 2'b01; i_data_bus = 32'hAAAAAAAA;
        settle();
        chk("str0_i_ready", 32'(i_ready), 32'd1);
        chk("str0_sw_valid", 32'(o_sw_valid), 32'd0);
        step();
        i_dest = 2'b10; i_data_bus = 32'hBBBBBBBB;
        settle();
        chk("str1_cmd", 32'(o_sw_cmd), 32'd1);
        chk("str1_data", o_sw_data, 32'hAAAAAAAA);
        chk("str1_i_ready", 32'(i_ready), 32'd1);
        step();
        i_dest = 2'b11; i_data_bus = 32'hCCCCCCCC;
        settle();
        chk("str2_cmd", 32'(o_sw_cmd), 32'd2);
        chk("str2_data", o_sw_data, 32'hBBBBBBBB);
        chk("str2_i_ready", 32'(i_ready), 32'd1);
        step();
        i_valid = 1'b0; i_dest = 2'b00; i_data_bus = '0;
        settle();
        chk("str3_cmd", 32'(o_sw_cmd), 32'd3);
        chk("str3_data", o_sw_data, 32'hCCCCCCCC);
        chk("str3_en", 32'(o_sw_en), 32'd1);
        step();
        chk("str_end_cmd", 32'(o_sw_cmd), 32'd0);
        chk("str_end_busy", 32'(o_busy), 32'd0);
        chk("str_cnt_high", 32'(o_cnt_high), 32'd2);
        chk("str_cnt_low", 32'(o_cnt_low), 32'd2);

        // Duplicate with low leg stalled for three cycles
        do_reset();
        i_ready_high = 1'b1; i_ready_low = 1'b0;
        i_valid = 1'b1; i_dest = 2'b11; i_data_bus = 32'hDDDDDDDD;
        settle();
        chk("dup_accept_ready", 32'(i_ready), 32'd1);
        step();
        i_valid = 1'b0; i_dest = 2'b00; i_data_bus = '0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("dup_stall%0d_cmd", k), 32'(o_sw_cmd), (SPLIT && k == 0) ? 32'd2 : 32'd0);
            chk($sformatf("dup_stall%0d_i_ready", k), 32'(i_ready), 32'd0);
            chk($sformatf("dup_stall%0d_busy", k), 32'(o_busy), 32'd1);
            step();
        end
        i_ready_low = 1'b1;
        settle();
        chk("dup_final_cmd", 32'(o_sw_cmd), SPLIT ? 32'd1 : 32'd3);
        chk("dup_final_data", o_sw_data, 32'hDDDDDDDD);
        chk("dup_final_i_ready", 32'(i_ready), 32'd1);
        step();
        chk("dup_cnt_high", 32'(o_cnt_high), 32'd1);
        chk("dup_cnt_low", 32'(o_cnt_low), 32'd1);
        chk("dup_busy", 32'(o_busy), 32'd0);

        // Drop of a dest==00 beat, then a normal low-leg beat
        do_reset();
        i_ready_high = 1'b1; i_ready_low = 1'b1;
        i_valid = 1'b1; i_dest = 2'b00; i_data_bus = 32'hEEEEEEEE;
        settle();
        chk("drop_i_ready", 32'(i_ready), 32'd1);
        step();
        i_dest = 2'b01; i_data_bus = 32'h12345678;
        settle();
        chk("drop_sw_valid", 32'(o_sw_valid), 32'd0);
        chk("drop_sw_data", o_sw_data, 32'd0);
        chk("drop_busy", 32'(o_busy), 32'd0);
        chk("drop_next_ready", 32'(i_ready), 32'd1);
        step();
        i_valid = 1'b0; i_dest = 2'b00; i_data_bus = '0;
        settle();
        chk("drop_next_cmd", 32'(o_sw_cmd), 32'd1);
        chk("drop_next_data", o_sw_data, 32'h12345678);
        step();
        chk("drop_cnt_low", 32'(o_cnt_low), 32'd1);
        chk("drop_cnt_high", 32'(o_cnt_high), 32'd0);

        // Saturation: 20 low-leg beats on a 4-bit counter
        do_reset();
        i_ready_high = 1'b1; i_ready_low = 1'b1;
        i_valid = 1'b1; i_dest = 2'b01;
        for (int k = 0; k < 20; k++) begin
            i_data_bus = 32'(k + 1);
            step();
        end
        i_valid = 1'b0; i_dest = 2'b00; i_data_bus = '0;
        step(); step();
        chk("sat_cnt_low", 32'(o_cnt_low), 32'd15);
        chk("sat_cnt_high", 32'(o_cnt_high), 32'd0);

        // Reset while a high-leg beat is held
        do_reset();
        i_ready_high = 1'b0; i_ready_low = 1'b1;
        i_valid = 1'b1; i_dest = 2'b10; i_data_bus = 32'hFFFF0000;
        step();
        i_valid = 1'b0; i_dest = 2'b00; i_data_bus = '0;
        settle();
        chk("hold_busy", 32'(o_busy), 32'd1);
        chk("hold_i_ready", 32'(i_ready), 32'd0);
        chk("hold_cmd", 32'(o_sw_cmd), 32'd0);
        rst = 1'b0;
        settle();
        chk("hold_rst_busy", 32'(o_busy), 32'd0);
        chk("hold_rst_i_ready", 32'(i_ready), 32'd1);
        step();
        rst = 1'b1;
        i_ready_high = 1'b1;
        settle();
        chk("hold_after_sw_valid", 32'(o_sw_valid), 32'd0);
        chk("hold_after_cmd", 32'(o_sw_cmd), 32'd0);
        step();
        chk("hold_after_cnt_high", 32'(o_cnt_high), 32'd0);
        chk("hold_after_busy", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
